// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: control-word layout,
// datapath width defaults and the bubble control encoding.
package mips_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_RWIDTH = 5;
  localparam int CTRL_W     = 9;

  // Bit positions inside the 9-bit decoded control word
  localparam int CTRL_REG_WRITE = 8;
  localparam int CTRL_MEM_TO_REG = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_ALU_SRC   = 3;
  localparam int CTRL_REG_DST   = 2;
  localparam int CTRL_ALU_OP    = 0;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 9'b0_0000_0000;

  function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_READ];
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard equation: a valid load in EX whose
// destination (rt, non-zero) is a source of the valid instruction in ID.
module load_use_detect #(
  parameter int RWIDTH = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [RWIDTH-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [RWIDTH-1:0] id_rs,
  input  logic [RWIDTH-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              hazard
);

  logic rt_nonzero_s;
  logic src_match_s;

  // $0 is hard-wired zero, so a load targeting it never feeds anyone
  always_comb begin
    rt_nonzero_s = (ex_rt != {RWIDTH{1'b0}});
    src_match_s  = (ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt));
    hazard       = ex_valid & ex_mem_read & rt_nonzero_s & id_valid & src_match_s;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, external stall
// and flush. Optional saturating counters enabled by ID_EX_PERF_CNT_EN.
module id_ex_stage_reg
  import mips_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int RWIDTH    = DEF_RWIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 ex_stall,
  input  logic                 id_valid,
  input  logic [DWIDTH-1:0]    id_pc4,
  input  logic [DWIDTH-1:0]    id_rs_data,
  input  logic [DWIDTH-1:0]    id_rt_data,
  input  logic [DWIDTH-1:0]    id_imm,
  input  logic [RWIDTH-1:0]    id_rs,
  input  logic [RWIDTH-1:0]    id_rt,
  input  logic [RWIDTH-1:0]    id_rd,
  input  logic                 id_uses_rt,
  input  logic [CTRL_W-1:0]    id_ctrl,
  output logic                 ex_valid,
  output logic [DWIDTH-1:0]    ex_pc4,
  output logic [DWIDTH-1:0]    ex_rs_data,
  output logic [DWIDTH-1:0]    ex_rt_data,
  output logic [DWIDTH-1:0]    ex_imm,
  output logic [RWIDTH-1:0]    ex_rs,
  output logic [RWIDTH-1:0]    ex_rt,
  output logic [RWIDTH-1:0]    ex_rd,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic                 id_stall,
  output logic [CNT_WIDTH-1:0] bubble_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  logic                valid_q,   valid_d;
  logic [DWIDTH-1:0]   pc4_q,     pc4_d;
  logic [DWIDTH-1:0]   rs_data_q, rs_data_d;
  logic [DWIDTH-1:0]   rt_data_q, rt_data_d;
  logic [DWIDTH-1:0]   imm_q,     imm_d;
  logic [RWIDTH-1:0]   rs_q,      rs_d;
  logic [RWIDTH-1:0]   rt_q,      rt_d;
  logic [RWIDTH-1:0]   rd_q,      rd_d;
  logic [CTRL_W-1:0]   ctrl_q,    ctrl_d;

  logic hazard_s;
  logic clear_s;
  logic load_s;

  load_use_detect #(.RWIDTH(RWIDTH)) u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_is_load(ctrl_q)),
    .ex_rt       (rt_q),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .hazard      (hazard_s)
  );

  // Flush beats stall; a hazard bubble only goes in once EX is free to move
  always_comb begin
    clear_s  = flush | (~ex_stall & hazard_s);
    load_s   = ~flush & ~ex_stall & ~hazard_s;
    id_stall = ~rst & ~flush & (ex_stall | hazard_s);
  end

  always_comb begin
    valid_d   = valid_q;
    pc4_d     = pc4_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    if (clear_s) begin
      valid_d   = 1'b0;
      pc4_d     = {DWIDTH{1'b0}};
      rs_data_d = {DWIDTH{1'b0}};
      rt_data_d = {DWIDTH{1'b0}};
      imm_d     = {DWIDTH{1'b0}};
      rs_d      = {RWIDTH{1'b0}};
      rt_d      = {RWIDTH{1'b0}};
      rd_d      = {RWIDTH{1'b0}};
      ctrl_d    = CTRL_BUBBLE;
    end else if (load_s) begin
      valid_d   = id_valid;
      pc4_d     = id_pc4;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      ctrl_d    = id_valid ? id_ctrl : CTRL_BUBBLE;
    end else begin
      valid_d   = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc4_q     <= {DWIDTH{1'b0}};
      rs_data_q <= {DWIDTH{1'b0}};
      rt_data_q <= {DWIDTH{1'b0}};
      imm_q     <= {DWIDTH{1'b0}};
      rs_q      <= {RWIDTH{1'b0}};
      rt_q      <= {RWIDTH{1'b0}};
      rd_q      <= {RWIDTH{1'b0}};
      ctrl_q    <= CTRL_BUBBLE;
    end else begin
      valid_q   <= valid_d;
      pc4_q     <= pc4_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_pc4     = pc4_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_ctrl    = ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q,  stall_cnt_d;

  // Saturating event counters; they stick at all-ones rather than wrap
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (~flush & ~ex_stall & hazard_s & (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
    if (~flush & ex_stall & (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= {CNT_WIDTH{1'b0}};
      stall_cnt_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`else
  assign bubble_cnt = {CNT_WIDTH{1'b0}};
  assign stall_cnt  = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized + directed bench for id_ex_stage_reg against a cycle-level
// reference model of the ID/EX priority rules.
module tb_id_ex_stage_reg;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, ex_stall, id_valid, id_uses_rt;
  logic [31:0]   id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic [8:0]    id_ctrl;
  logic          ex_valid, id_stall;
  logic [31:0]   ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [8:0]    ex_ctrl;
  logic [CW-1:0] bubble_cnt, stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model of EX contents and counters
  logic        m_valid;
  logic [31:0] m_pc4, m_rs_data, m_rt_data, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [8:0]  m_ctrl;
  int          m_bub, m_stl;
  logic        last_stall;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DWIDTH(32), .RWIDTH(5), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall),
    .id_valid(id_valid), .id_pc4(id_pc4), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .id_stall(id_stall),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear_ex();
    m_valid = 1'b0; m_pc4 = 32'd0; m_rs_data = 32'd0; m_rt_data = 32'd0;
    m_imm = 32'd0; m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0; m_ctrl = 9'd0;
  endtask

  function automatic int sat(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  task automatic check_outputs();
    check_eq("ex_valid",   ex_valid,   m_valid);
    check_eq("ex_pc4",     ex_pc4,     m_pc4);
    check_eq("ex_rs_data", ex_rs_data, m_rs_data);
    check_eq("ex_rt_data", ex_rt_data, m_rt_data);
    check_eq("ex_imm",     ex_imm,     m_imm);
    check_eq("ex_rs",      ex_rs,      m_rs);
    check_eq("ex_rt",      ex_rt,      m_rt);
    check_eq("ex_rd",      ex_rd,      m_rd);
    check_eq("ex_ctrl",    ex_ctrl,    m_ctrl);
`ifdef ID_EX_PERF_CNT_EN
    check_eq("bubble_cnt", bubble_cnt, m_bub);
    check_eq("stall_cnt",  stall_cnt,  m_stl);
`else
    check_eq("bubble_cnt", bubble_cnt, 0);
    check_eq("stall_cnt",  stall_cnt,  0);
`endif
  endtask

  // one clock: check id_stall mid-cycle, advance model, check EX after edge
  task automatic run_cycle();
    logic hz, exp_stall;
    @(negedge clk);
    hz = m_valid && m_ctrl[6] && (m_rt != 5'd0) && id_valid &&
         ((m_rt == id_rs) || (id_uses_rt && (m_rt == id_rt)));
    exp_stall  = !rst && !flush && (ex_stall || hz);
    last_stall = id_stall;
    check_eq("id_stall", id_stall, exp_stall);
    if (rst) begin
      model_clear_ex(); m_bub = 0; m_stl = 0;
    end else if (flush) begin
      model_clear_ex();
    end else if (ex_stall) begin
      m_stl = sat(m_stl);
    end else if (hz) begin
      model_clear_ex(); m_bub = sat(m_bub);
    end else begin
      m_valid = id_valid; m_pc4 = id_pc4; m_rs_data = id_rs_data;
      m_rt_data = id_rt_data; m_imm = id_imm; m_rs = id_rs; m_rt = id_rt;
      m_rd = id_rd; m_ctrl = id_valid ? id_ctrl : 9'd0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic rand_id();
    id_valid   = ($urandom_range(0, 9) != 0);
    id_pc4     = $urandom;
    id_rs_data = $urandom;
    id_rt_data = $urandom;
    id_imm     = $urandom;
    id_rs      = 5'($urandom_range(0, 3));
    id_rt      = 5'($urandom_range(0, 3));
    id_rd      = 5'($urandom_range(0, 31));
    id_uses_rt = 1'($urandom_range(0, 1));
    id_ctrl    = 9'($urandom_range(0, 511));
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses_rt, input logic [8:0] ctrl);
    rand_id();
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_ctrl = ctrl;
  endtask

  localparam logic [8:0] LW_CTRL  = 9'b1_1100_1000;
  localparam logic [8:0] ADD_CTRL = 9'b1_0000_0110;

  initial begin
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    rand_id();
    m_bub = 0; m_stl = 0; model_clear_ex();

    // reset with random ID inputs
    repeat (2) begin rand_id(); run_cycle(); end
    check_eq("rst_valid", ex_valid, 1'b0);
    rst = 1'b0;
    set_id(5'd1, 5'd2, 1'b1, ADD_CTRL);
    id_imm = 32'hFFFF_FFF0;
    run_cycle();
    check_eq("lat_imm", ex_imm, 32'hFFFF_FFF0);

    // load-use: lw $8 then add using $8
    set_id(5'd2, 5'd8, 1'b0, LW_CTRL); run_cycle();
    set_id(5'd8, 5'd3, 1'b1, ADD_CTRL); run_cycle();
    check_eq("lu_stall", last_stall, 1'b1);
    check_eq("lu_bub_valid", ex_valid, 1'b0);
    check_eq("lu_bub_ctrl", ex_ctrl, 9'd0);
    run_cycle();
    check_eq("lu_nostall", last_stall, 1'b0);
    check_eq("lu_add_rs", ex_rs, 5'd8);

    // $0 destination and unused rt
    set_id(5'd2, 5'd0, 1'b0, LW_CTRL); run_cycle();
    set_id(5'd0, 5'd4, 1'b1, ADD_CTRL); run_cycle();
    check_eq("r0_nostall", last_stall, 1'b0);
    set_id(5'd2, 5'd9, 1'b0, LW_CTRL); run_cycle();
    set_id(5'd1, 5'd9, 1'b0, ADD_CTRL); run_cycle();
    check_eq("unused_rt_nostall", last_stall, 1'b0);

    // flush beats stall and hazard
    set_id(5'd2, 5'd8, 1'b0, LW_CTRL); run_cycle();
    set_id(5'd8, 5'd8, 1'b1, ADD_CTRL); flush = 1'b1; ex_stall = 1'b1; run_cycle();
    check_eq("flush_stall", last_stall, 1'b0);
    check_eq("flush_valid", ex_valid, 1'b0);
    flush = 1'b0; ex_stall = 1'b0;

    // ex_stall hold for 3 cycles
    rst = 1'b1; run_cycle(); rst = 1'b0;
    set_id(5'd5, 5'd6, 1'b1, ADD_CTRL); run_cycle();
    ex_stall = 1'b1;
    repeat (3) begin
      rand_id(); run_cycle();
      check_eq("hold_stall", last_stall, 1'b1);
    end
    ex_stall = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
    check_eq("stall_cnt3", stall_cnt, 4'd3);
`endif

    // 20 hazard bubbles saturate the 4-bit bubble counter
    rst = 1'b1; run_cycle(); rst = 1'b0;
    set_id(5'd8, 5'd8, 1'b0, LW_CTRL);
    repeat (40) run_cycle();
`ifdef ID_EX_PERF_CNT_EN
    check_eq("bubble_sat", bubble_cnt, 4'd15);
`else
    check_eq("bubble_off", bubble_cnt, 4'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_id();
      if (id_ctrl[8]) id_ctrl[6] = 1'b1;
      rst      = ($urandom_range(0, 49) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      ex_stall = ($urandom_range(0, 4) == 0);
      run_cycle();
    end

    // reset asserted mid-stall
    rst = 1'b0; flush = 1'b0; ex_stall = 1'b1; run_cycle();
    rst = 1'b1; run_cycle();
    check_eq("rst_mid_stall", last_stall, 1'b0);
    check_eq("rst_mid_valid", ex_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
